// File: rtl/pool_pkg.sv
// Shared definitions for the pooling stage: FSM encoding, DRAM address field
// layout and layer base addresses common with the convolution stage.
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int CH_BITS    = 4;
    localparam int Y_BITS     = 5;
    localparam int X_BITS     = 5;
    localparam int FIELD_BITS = CH_BITS + Y_BITS + X_BITS;

    localparam int CONV_OFMAP_BASE = 131072;
    localparam int POOL_OFMAP_BASE = 196608;

    function automatic logic [FIELD_BITS-1:0] map_offset(
        input logic [CH_BITS-1:0] ch,
        input logic [Y_BITS-1:0]  y,
        input logic [X_BITS-1:0]  x
    );
        return {ch, y, x};
    endfunction

endpackage

// File: rtl/smax2.sv
// Combinational two's-complement signed maximum of two words.
module smax2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    assign y = ($signed(a) < $signed(b)) ? b : a;

endmodule

// File: rtl/maxpool_relu.sv
// ReLU + 2x2 stride-2 max pooling over a DRAM-resident feature map: four reads
// per output window followed by one write of max(0, a, b, c, d).
module maxpool_relu
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 18,
    parameter int IFMAP_WIDTH  = 10,
    parameter int IFMAP_HEIGHT = 10,
    parameter int NUM_CHNL     = 16,
    parameter int SRC_BASE     = CONV_OFMAP_BASE,
    parameter int DST_BASE     = POOL_OFMAP_BASE
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    localparam logic [X_BITS-1:0]     OX_MAX   = X_BITS'(IFMAP_WIDTH / 2 - 1);
    localparam logic [Y_BITS-1:0]     OY_MAX   = Y_BITS'(IFMAP_HEIGHT / 2 - 1);
    localparam logic [CH_BITS-1:0]    CH_MAX   = CH_BITS'(NUM_CHNL - 1);
    localparam logic [ADDR_WIDTH-1:0] SRC_ADDR = ADDR_WIDTH'(SRC_BASE);
    localparam logic [ADDR_WIDTH-1:0] DST_ADDR = ADDR_WIDTH'(DST_BASE);

    state_t                state;
    state_t                state_next;
    logic [1:0]            dpos;
    logic [X_BITS-1:0]     ox;
    logic [Y_BITS-1:0]     oy;
    logic [CH_BITS-1:0]    ch;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] max_out;
    logic [X_BITS-1:0]     src_x;
    logic [Y_BITS-1:0]     src_y;
    logic                  last_win;
    logic                  unused_dram_valid;

    assign unused_dram_valid = dram_valid;

    // dpos bit 0 selects dx and bit 1 selects dy within the 2x2 window
    assign src_x    = {ox[X_BITS-2:0], dpos[0]};
    assign src_y    = {oy[Y_BITS-2:0], dpos[1]};
    assign last_win = (ox == OX_MAX) && (oy == OY_MAX) && (ch == CH_MAX);

    // One comparator serves both the running acc update and the final write value
    smax2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_max (
        .a(acc),
        .b(data_in),
        .y(max_out)
    );

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        addr_in    = '0;
        addr_out   = '0;
        data_out   = '0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                dram_en_rd = 1'b1;
                addr_in    = SRC_ADDR + ADDR_WIDTH'(map_offset(ch, src_y, src_x));
                if (dpos == 2'd3) begin
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                dram_en_wr = 1'b1;
                addr_out   = DST_ADDR + ADDR_WIDTH'(map_offset(ch, oy, ox));
                data_out   = max_out;
                state_next = last_win ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read data lags its address by one cycle, so the zero seed lands with the first
    // read and each later RD cycle folds in the previous read's data.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            dpos <= 2'd0;
            acc  <= '0;
        end else if (state == ST_RD) begin
            dpos <= dpos + 2'd1;
            acc  <= (dpos == 2'd0) ? '0 : max_out;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            ox <= '0;
            oy <= '0;
            ch <= '0;
        end else if (state == ST_WR) begin
            if (ox == OX_MAX) begin
                ox <= '0;
                if (oy == OY_MAX) begin
                    oy <= '0;
                    ch <= (ch == CH_MAX) ? '0 : ch + 1'b1;
                end else begin
                    oy <= oy + 1'b1;
                end
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_relu.sv
// Directed bench for maxpool_relu: a DRAM model answers reads one cycle late
// and logs writes; results are compared with hand-computed and modelled values.
module tb_maxpool_relu;

    localparam logic [17:0] SRC = 18'd131072;
    localparam logic [17:0] DST = 18'd196608;

    typedef struct {
        logic        en;
        logic        rd;
        logic        wr;
        logic [31:0] a_in;
        logic [31:0] a_out;
        logic [31:0] d_out;
        logic        dn;
    } vec_t;

    logic        clk = 1'b0;
    logic        srstn = 1'b1;
    logic        enable = 1'b0;
    logic        dram_valid = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic [17:0] addr_in;
    logic [17:0] addr_out;
    logic        dram_en_rd;
    logic        dram_en_wr;
    logic        done;

    logic [31:0] src_mem [0:16383];
    logic [31:0] rd_pending = 32'd0;
    logic [17:0] rd_off;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          both_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    vec_t        vecs [12];

    maxpool_relu dut (
        .clk(clk),
        .srstn(srstn),
        .enable(enable),
        .dram_valid(dram_valid),
        .data_in(data_in),
        .data_out(data_out),
        .addr_in(addr_in),
        .addr_out(addr_out),
        .dram_en_rd(dram_en_rd),
        .dram_en_wr(dram_en_wr),
        .done(done)
    );

    always #5 clk = ~clk;

    assign rd_off = addr_in - SRC;

    // DRAM model: address seen in a cycle is answered after the next rising edge
    always @(negedge clk) begin
        if (dram_en_rd) rd_pending = src_mem[rd_off[13:0]];
        else            rd_pending = 32'hDEAD_BEEF;
        if (dram_en_wr) begin
            wr_addr_q.push_back(32'(addr_out));
            wr_data_q.push_back(data_out);
        end
        if (dram_en_rd && dram_en_wr) both_cnt++;
    end

    always @(posedge clk) data_in <= rd_pending;

    function automatic vec_t mk_vec(input logic en, input logic rd, input logic wr,
                                    input logic [31:0] a_in, input logic [31:0] a_out,
                                    input logic [31:0] d_out, input logic dn);
        vec_t v;
        v.en = en; v.rd = rd; v.wr = wr; v.a_in = a_in;
        v.a_out = a_out; v.d_out = d_out; v.dn = dn;
        return v;
    endfunction

    function automatic logic [31:0] golden(input int c, input int oy, input int ox);
        int m = 0;
        int v;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = c * 100 + (2 * oy + dy) * 10 + (2 * ox + dx) - 500;
                if (v > m) m = v;
            end
        return 32'(m);
    endfunction

    function automatic logic [31:0] dst_addr(input int n);
        return 32'(DST) + 32'((n / 25) * 1024 + ((n / 5) % 5) * 32 + (n % 5));
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic apply_reset();
        enable = 1'b0;
        srstn = 1'b0;
        repeat (2) @(negedge clk);
        srstn = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16384; i++) src_mem[i] = 32'd0;
        for (int c = 0; c < 16; c++)
            for (int y = 0; y < 10; y++)
                for (int x = 0; x < 10; x++)
                    src_mem[c * 1024 + y * 32 + x] = 32'(c * 100 + y * 10 + x - 500);
    endtask

    task automatic apply_stimulus_start();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic check_run(input string tag, input int base);
        for (int n = 0; n < 400; n++) begin
            check_output($sformatf("%s_addr[%0d]", tag, n),
                         (base + n < wr_addr_q.size()) ? wr_addr_q[base + n] : 32'hFFFF_FFFF,
                         dst_addr(n));
            check_output($sformatf("%s_data[%0d]", tag, n),
                         (base + n < wr_data_q.size()) ? wr_data_q[base + n] : 32'hFFFF_FFFF,
                         golden(n / 25, (n / 5) % 5, n % 5));
        end
    endtask

    initial begin
        int done_cnt;
        int done_cyc [2];
        int idle_cnt;

        // Single-window data: window (0,0,0) positives, window (1,0,0) all negative
        for (int i = 0; i < 16384; i++) src_mem[i] = 32'd0;
        src_mem[0]  = 32'h0001_8000;
        src_mem[1]  = 32'hFFFE_0000;
        src_mem[32] = 32'h0003_4000;
        src_mem[33] = 32'h0000_8000;
        src_mem[2]  = 32'hFFFF_0000;
        src_mem[3]  = 32'hFFFB_0000;
        src_mem[34] = 32'h8000_0000;
        src_mem[35] = 32'hFFFE_0000;

        vecs[0]  = mk_vec(0, 0, 0, 0,      0,      0,            0);
        vecs[1]  = mk_vec(1, 0, 0, 0,      0,      0,            0);
        vecs[2]  = mk_vec(0, 1, 0, 131072, 0,      0,            0);
        vecs[3]  = mk_vec(0, 1, 0, 131073, 0,      0,            0);
        vecs[4]  = mk_vec(0, 1, 0, 131104, 0,      0,            0);
        vecs[5]  = mk_vec(0, 1, 0, 131105, 0,      0,            0);
        vecs[6]  = mk_vec(0, 0, 1, 0,      196608, 32'h0003_4000, 0);
        vecs[7]  = mk_vec(0, 1, 0, 131074, 0,      0,            0);
        vecs[8]  = mk_vec(0, 1, 0, 131075, 0,      0,            0);
        vecs[9]  = mk_vec(0, 1, 0, 131106, 0,      0,            0);
        vecs[10] = mk_vec(0, 1, 0, 131107, 0,      0,            0);
        vecs[11] = mk_vec(0, 0, 1, 0,      196609, 0,            0);

        apply_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            enable = vecs[i].en;
            check_output($sformatf("vec%0d_rd", i), 32'(dram_en_rd), 32'(vecs[i].rd));
            check_output($sformatf("vec%0d_wr", i), 32'(dram_en_wr), 32'(vecs[i].wr));
            check_output($sformatf("vec%0d_addr_in", i), 32'(addr_in), vecs[i].a_in);
            check_output($sformatf("vec%0d_addr_out", i), 32'(addr_out), vecs[i].a_out);
            check_output($sformatf("vec%0d_data_out", i), data_out, vecs[i].d_out);
            check_output($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
        end

        // Full run over a signed ramp
        apply_reset();
        load_ramp();
        done_cnt = 0;
        done_cyc[0] = -1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 2010; k++) begin
            @(negedge clk);
            #1;
            enable = 1'b0;
            if (done) begin
                if (done_cnt == 0) done_cyc[0] = k;
                done_cnt++;
            end
        end
        check_output("full_done_count", 32'(done_cnt), 32'd1);
        check_output("full_done_cycle", 32'(done_cyc[0]), 32'd2001);
        check_output("full_write_count", 32'(wr_addr_q.size()), 32'd400);
        check_run("full", 0);

        // Asynchronous reset in the middle of window 37
        apply_reset();
        apply_stimulus_start();
        for (int k = 0; k < 400 && wr_addr_q.size() < 37; k++) begin
            @(negedge clk);
            #1;
        end
        check_output("mid_reached_w37", 32'(wr_addr_q.size()), 32'd37);
        @(posedge clk);
        @(posedge clk);
        #2;
        srstn = 1'b0;
        #1;
        check_output("mid_rst_rd", 32'(dram_en_rd), 32'd0);
        check_output("mid_rst_wr", 32'(dram_en_wr), 32'd0);
        check_output("mid_rst_addr_in", 32'(addr_in), 32'd0);
        check_output("mid_rst_addr_out", 32'(addr_out), 32'd0);
        check_output("mid_rst_data_out", data_out, 32'd0);
        check_output("mid_rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check_output("mid_rst_no_write", 32'(wr_addr_q.size()), 32'd37);
        srstn = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check_output("restart_rd", 32'(dram_en_rd), 32'd1);
        check_output("restart_addr_in", 32'(addr_in), 32'(SRC));
        for (int k = 0; k < 30 && wr_addr_q.size() < 38; k++) begin
            @(negedge clk);
            #1;
        end
        check_output("restart_write_count", 32'(wr_addr_q.size()), 32'd38);
        check_output("restart_addr_out",
                     (wr_addr_q.size() > 37) ? wr_addr_q[37] : 32'hFFFF_FFFF, 32'(DST));
        check_output("restart_data_out",
                     (wr_data_q.size() > 37) ? wr_data_q[37] : 32'hFFFF_FFFF, golden(0, 0, 0));

        // Back-to-back runs with enable held high
        apply_reset();
        done_cnt = 0;
        idle_cnt = 0;
        done_cyc[0] = -1;
        done_cyc[1] = -1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 4006; k++) begin
            @(negedge clk);
            #1;
            if (done) begin
                if (done_cnt < 2) done_cyc[done_cnt] = k;
                done_cnt++;
            end
            if (!dram_en_rd && !dram_en_wr && !done) idle_cnt++;
        end
        enable = 1'b0;
        check_output("b2b_done_count", 32'(done_cnt), 32'd2);
        check_output("b2b_done_cycle0", 32'(done_cyc[0]), 32'd2001);
        check_output("b2b_done_cycle1", 32'(done_cyc[1]), 32'd4003);
        check_output("b2b_idle_cycles", 32'(idle_cnt), 32'd2);
        check_output("b2b_write_count", 32'(wr_addr_q.size()), 32'd800);
        check_run("b2b_run1", 0);
        check_run("b2b_run2", 400);

        check_output("rd_wr_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
